// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared defaults and clear-FSM state encoding for regfile_mp.
//  Revision : 1.0
// ============================================================================
package regfile_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_clr_fsm
//  Purpose  : Sequential clear engine: walks a pointer over every entry,
//             strobing a zero-write per cycle, then pulses clr_done once.
//  Revision : 1.0
// ============================================================================
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          clr_done_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_ptr_o
);

    localparam logic [AW-1:0] PTR_LAST = '1;

    clr_state_e    state_q;
    logic [AW-1:0] ptr_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (clr_req_i) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    ptr_q <= ptr_q + AW'(1);
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                // clr_req is deliberately ignored here; a held request restarts from IDLE
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_done_o = done_q;
    assign clr_we_o   = busy_q;
    assign clr_ptr_o  = ptr_q;

endmodule : regfile_clr_fsm
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port register file with a live PC entry and a sequential
//             clear engine. Define REGFILE_BYPASS_EN for write-to-read bypass.
//  Revision : 1.0
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int PC_IDX = (1 << AW) - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic          we1,
    input  logic [AW-1:0] wa2,
    input  logic [DW-1:0] wd2,
    input  logic          we2,
    input  logic [DW-1:0] pc_in,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          clr_we;
    logic [AW-1:0] clr_ptr;

    regfile_clr_fsm #(
        .AW (AW)
    ) u_clr_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (clr_req),
        .busy_o     (busy),
        .clr_done_o (clr_done),
        .clr_we_o   (clr_we),
        .clr_ptr_o  (clr_ptr)
    );

    // Later assignments win: port 2 over port 1 over the PC update
    always_comb begin
        mem_d = mem_q;
        if (clr_we) begin
            mem_d[clr_ptr] = '0;
        end else begin
            mem_d[PC_ADDR] = pc_in;
            if (we1) mem_d[wa1] = wd1;
            if (we2) mem_d[wa2] = wd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [AW-1:0] ra_v;
        logic [DW-1:0] rd_v;

        assign ra_v = (p == 0) ? ra1 : ra2;

        always_comb begin
            if (ra_v == PC_ADDR) begin
                rd_v = pc_in;
            end
`ifdef REGFILE_BYPASS_EN
            else if (!busy && we2 && (wa2 == ra_v)) begin
                rd_v = wd2;
            end else if (!busy && we1 && (wa1 == ra_v)) begin
                rd_v = wd1;
            end
`endif
            else begin
                rd_v = mem_q[ra_v];
            end
        end
    end

    assign rd1 = g_rd[0].rd_v;
    assign rd2 = g_rd[1].rd_v;

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp against an array-based model.
//  Revision : 1.0
// ============================================================================
module tb_regfile_mp;

    localparam int DEPTH = 16;
    localparam int PC    = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ra1 = '0, ra2 = '0, wa1 = '0, wa2 = '0;
    logic [31:0] wd1 = '0, wd2 = '0, pc_in = '0;
    logic        we1 = 1'b0, we2 = 1'b0, clr_req = 1'b0;
    logic [31:0] rd1, rd2;
    logic        busy, clr_done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m [DEPTH];
    int          clr_k = -1;   // -1 idle, 0..DEPTH-1 clearing entry k, DEPTH = done cycle

    regfile_mp #(
        .DW     (32),
        .AW     (4),
        .PC_IDX (15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .wa1      (wa1),
        .wd1      (wd1),
        .we1      (we1),
        .wa2      (wa2),
        .wd2      (wd2),
        .we2      (we2),
        .pc_in    (pc_in),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic bit model_busy();
        return (clr_k >= 0) && (clr_k < DEPTH);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] ra);
        if (int'(ra) == PC) return pc_in;
`ifdef REGFILE_BYPASS_EN
        if (!model_busy()) begin
            if (we2 && wa2 == ra) return wd2;
            if (we1 && wa1 == ra) return wd1;
        end
`endif
        return m[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        clr_k = -1;
    endtask

    task automatic model_step();
        if (model_busy()) begin
            m[clr_k] = '0;
            clr_k++;
        end else begin
            m[PC] = pc_in;
            if (we1) m[wa1] = wd1;
            if (we2) m[wa2] = wd2;
            if (clr_k == DEPTH) clr_k = -1;
            else if (clr_req)   clr_k = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/rd1"}, rd1, exp_rd(ra1));
        chk({tag, "/rd2"}, rd2, exp_rd(ra2));
        chk({tag, "/busy"}, {31'd0, busy}, {31'd0, model_busy()});
        chk({tag, "/clr_done"}, {31'd0, clr_done}, {31'd0, (clr_k == DEPTH)});
    endtask

    task automatic fill_all();
        pc_in = 32'hFFFF_FFFF;
        for (int i = 0; i < DEPTH; i++) begin
            we1 = 1'b1; wa1 = 4'(i); wd1 = 32'hFFFF_FFFF;
            tick();
        end
        we1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ra1 = 4'(i); ra2 = 4'(DEPTH - 1 - i);
            #1 check_all("fill");
        end
    endtask

    task automatic readback_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            ra1 = 4'(i);
            #1 chk(tag, rd1, (i == PC) ? pc_in : 32'h0);
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;

        // Reset state
        model_reset();
        pc_in = 32'h100; ra1 = 4'd3; ra2 = 4'd15;
        #1 check_all("reset");
        chk("reset/ra1_3", rd1, 32'h0);
        chk("reset/ra2_pc", rd2, 32'h100);
        repeat (2) tick();
        rst_n = 1'b1;
        #1 check_all("post_reset");

        // Dual write to the same entry: port 2 wins
        we1 = 1'b1; wa1 = 4'd2; wd1 = 32'hAAAA;
        we2 = 1'b1; wa2 = 4'd2; wd2 = 32'h5555;
        ra1 = 4'd2;
        #1 check_all("dual_pre");
        tick();
        we1 = 1'b0; we2 = 1'b0;
        #1 check_all("dual_post");
        chk("dual_value", rd1, 32'h5555);

        // Same-cycle write-then-read
        ra1 = 4'd4; we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h1234;
        #1 check_all("byp_pre");
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_cycle", rd1, 32'h1234);
`else
        chk("byp_same_cycle", rd1, 32'h0);
`endif
        tick();
        we1 = 1'b0;
        #1 chk("byp_after_edge", rd1, 32'h1234);

        // PC entry always reads pc_in
        pc_in = 32'h200; we1 = 1'b1; wa1 = 4'd15; wd1 = 32'hDEAD; ra1 = 4'd15;
        #1 chk("pc_read_during_write", rd1, 32'h200);
        tick();
        we1 = 1'b0;
        #1 chk("pc_read_after_write", rd1, 32'h200);
        pc_in = 32'h300;
        #1 chk("pc_read_follows_input", rd1, 32'h300);

        // Randomized traffic with occasional clears
        for (int n = 0; n < 400; n++) begin
            ra1 = 4'($urandom); ra2 = 4'($urandom);
            wa1 = 4'($urandom); wa2 = 4'($urandom);
            if (n % 7 == 0) wa2 = wa1;
            wd1 = $urandom; wd2 = $urandom; pc_in = $urandom;
            we1 = 1'($urandom); we2 = 1'($urandom);
            clr_req = ($urandom_range(0, 39) == 0);
            #1 check_all("rand");
            tick();
        end
        clr_req = 1'b0; we1 = 1'b0; we2 = 1'b0;
        for (int n = 0; n < 20 && clr_k != -1; n++) tick();
        chk("rand_drain_idle", clr_k, 32'hFFFF_FFFF);

        // Full clear with writes attempted while busy
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < 20; c++) begin
            we1 = model_busy(); wa1 = 4'($urandom); wd1 = $urandom;
            ra1 = 4'($urandom); ra2 = 4'($urandom);
            #1 check_all("clear");
            if (busy) busy_cnt++;
            if (clr_done) begin done_cnt++; done_at = c; end
            tick();
        end
        we1 = 1'b0;
        chk("clear_busy_cycles", busy_cnt, 32'd16);
        chk("clear_done_pulses", done_cnt, 32'd1);
        chk("clear_done_cycle", done_at, 32'd16);
        readback_zero("clear_zero");

        // Reset in the middle of a clear
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, clr_done}, 32'd0);
        check_all("abort");
        repeat (2) tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1 check_all("abort_after");
            if (clr_done) done_cnt++;
            tick();
        end
        chk("abort_no_done", done_cnt, 32'd0);
        readback_zero("abort_zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_mp
`default_nettype wire
